// File: rtl/echo_delay_line.sv
// Echo engine: per channel y = sat(x + (g * d[n-D]) >>> GAIN_W) over one shared circular RAM.
// Latency: out_valid pulses 3*CHANNELS+1 cycles after accept; one frame per 3*CHANNELS+2 cycles.
// Backpressure: in_ready stays low while a frame is in flight; no output backpressure.
module echo_delay_line #(
  parameter int DATA_W   = 16,
  parameter int CHANNELS = 2,
  parameter int ADDR_W   = 12,
  parameter int GAIN_W   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [CHANNELS*DATA_W-1:0] in_data,
  input  logic [ADDR_W-1:0]          delay_num,
  input  logic [GAIN_W-1:0]          gain,
  input  logic                       fb_en,
  input  logic                       bypass,
  output logic                       out_valid,
  output logic [CHANNELS*DATA_W-1:0] out_data
);

  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int RAM_AW    = CH_W + ADDR_W;
  localparam int RAM_DEPTH = CHANNELS << ADDR_W;
  localparam int PROD_W    = DATA_W + GAIN_W + 1;
  localparam int SUM_W     = DATA_W + 1;
  localparam logic [CH_W-1:0]         LAST_CH = CH_W'(CHANNELS - 1);
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (DATA_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = SUM_W'(-(1 << (DATA_W - 1)));

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_MAC,
    S_WR,
    S_OUT
  } state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] delay;
    logic [GAIN_W-1:0] gain;
    logic              fb_en;
    logic              bypass;
  } cfg_t;

  state_t                     state, state_nxt;
  cfg_t                       cfg_q;
  logic [CH_W-1:0]            ch;
  logic [ADDR_W-1:0]          wr_ptr, fill, delay_eff, rd_ptr;
  logic [CHANNELS*DATA_W-1:0] in_q, frame_q;
  logic [DATA_W-1:0]          ram [RAM_DEPTH];
  logic [DATA_W-1:0]          ram_q;
  logic [RAM_AW-1:0]          rd_addr, wr_addr;
  logic                       accept;
  logic signed [DATA_W-1:0]   x_dat, tap_dat, y_nxt, y_q;
  logic signed [PROD_W-1:0]   tap_ext, gain_ext, prod;
  logic signed [SUM_W-1:0]    echo, sum;
  logic                       unused_frac;

  assign accept    = in_valid && in_ready;
  assign delay_eff = (cfg_q.delay == '0) ? ADDR_W'(1) : cfg_q.delay;
  assign rd_ptr    = wr_ptr - delay_eff;
  assign rd_addr   = {ch, rd_ptr};
  assign wr_addr   = {ch, wr_ptr};

  always_comb begin
    x_dat = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (ch == CH_W'(i)) x_dat = in_q[i*DATA_W +: DATA_W];
    end
  end

  // Taps older than the data written since reset read as silence, so stale RAM never leaks.
  assign tap_dat  = (delay_eff > fill) ? '0 : ram_q;
  assign tap_ext  = {{(GAIN_W + 1){tap_dat[DATA_W-1]}}, tap_dat};
  assign gain_ext = {{(DATA_W + 1){1'b0}}, cfg_q.gain};
  assign prod     = tap_ext * gain_ext;
  assign echo     = prod[PROD_W-1:GAIN_W];
  assign unused_frac = ^prod[GAIN_W-1:0];
  assign sum      = {x_dat[DATA_W-1], x_dat} + echo;

  always_comb begin
    y_nxt = sum[DATA_W-1:0];
    if (sum > SAT_MAX)      y_nxt = {1'b0, {(DATA_W - 1){1'b1}}};
    else if (sum < SAT_MIN) y_nxt = {1'b1, {(DATA_W - 1){1'b0}}};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = S_RD;
      S_RD:    state_nxt = S_MAC;
      S_MAC:   state_nxt = S_WR;
      S_WR:    state_nxt = (ch == LAST_CH) ? S_OUT : S_RD;
      S_OUT:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // RAM is never reset; the fill counter masks whatever it held before.
  always_ff @(posedge clk) begin
    if (state == S_RD) ram_q <= ram[rd_addr];
    if (state == S_WR) ram[wr_addr] <= cfg_q.fb_en ? y_q : x_dat;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      in_q      <= '0;
      frame_q   <= '0;
      cfg_q     <= '0;
      ch        <= '0;
      wr_ptr    <= '0;
      fill      <= '0;
      y_q       <= '0;
    end else begin
      in_ready  <= (state_nxt == S_IDLE);
      out_valid <= (state == S_OUT);
      case (state)
        S_IDLE: begin
          if (accept) begin
            in_q         <= in_data;
            cfg_q.delay  <= delay_num;
            cfg_q.gain   <= gain;
            cfg_q.fb_en  <= fb_en;
            cfg_q.bypass <= bypass;
            ch           <= '0;
          end
        end
        S_MAC: y_q <= y_nxt;
        S_WR: begin
          for (int i = 0; i < CHANNELS; i++) begin
            if (ch == CH_W'(i)) frame_q[i*DATA_W +: DATA_W] <= cfg_q.bypass ? x_dat : y_q;
          end
          if (ch != LAST_CH) ch <= ch + CH_W'(1);
        end
        S_OUT: begin
          out_data <= frame_q;
          wr_ptr   <= wr_ptr + ADDR_W'(1);
          if (fill != '1) fill <= fill + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
